// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, slice width and slice-count helper.
package alu_pkg;

  localparam int unsigned SLICE_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Number of slice cycles needed for a given operand width.
  function automatic int unsigned calc_nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/slice_serial_adder_ctrl_fa3.sv
// FA3: 3-bit ripple-carry adder slice, the shared datapath of the serial adder.
module slice_serial_adder_ctrl_fa3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       c_in,
  output logic [2:0] s,
  output logic       c_out
);

  logic c;

  // Ripple the carry through the three bit positions.
  always_comb begin
    c = c_in;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/slice_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one FA3 slice reused NSLICE times, LSB slice first.
// Optional macro SLICE_ADDSUB_EN adds a 'sub' port that turns the operation into a - b.
module slice_serial_adder_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SLICE_ADDSUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSLICE = calc_nslice(WIDTH);
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH == 0) begin : g_bad_width
    $error("slice_serial_adder_ctrl: WIDTH must be a non-zero multiple of 3");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [2:0]       slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] sh_next;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  slice_serial_adder_ctrl_fa3 u_fa3 (
    .a     (a_sh_q[2:0]),
    .b     (b_sh_q[2:0]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_co)
  );

  // Operand/carry values captured on an accepting edge.
`ifdef SLICE_ADDSUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // Slice sum enters at the top; after NSLICE shifts the register holds the full result.
  assign sh_next = WIDTH'({slice_s, sum_sh_q} >> SLICE_W);
  // On the final slice bit 2 is bit WIDTH-1, so this recovers the carry into the MSB.
  assign c_msb   = a_sh_q[2] ^ b_sh_q[2] ^ slice_s[2];
  assign last    = (idx_q == IdxW'(NSLICE - 1));

  // Next-state: accept in IDLE/DONE, process one slice per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      RUN: begin
        a_sh_d   = a_sh_q >> SLICE_W;
        b_sh_d   = b_sh_q >> SLICE_W;
        sum_sh_d = sh_next;
        carry_d  = slice_co;
        idx_d    = idx_q + IdxW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = sh_next;
          cout_d  = slice_co;
          ovf_d   = c_msb ^ slice_co;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = c_load;
          idx_d   = '0;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule
